// File: rtl/fft_stage_sched.sv
// Stage sequencer for the mixed-radix FFT: walks each stage's groups one per cycle,
// inserts a write-back gap between stages and delays the mux/PE controls to meet bank data.
module fft_stage_sched #(
    parameter int ADDR_WIDTH = 10,
    parameter int GRP_WIDTH  = 10,
    parameter int MAX_STAGES = 4,
    parameter int MEM_LAT    = 1,
    parameter int STAGE_GAP  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [2:0]                      cfg_num_stages,
    input  logic [3*MAX_STAGES-1:0]         cfg_stage_point,
    input  logic [MAX_STAGES-1:0]           cfg_stage_p2mode,
    input  logic [GRP_WIDTH*MAX_STAGES-1:0] cfg_stage_groups,
    input  logic                            pe_ready,
    output logic                            mem_rd_en,
    output logic [ADDR_WIDTH-1:0]           mem_rd_addr,
    output logic [$clog2(MAX_STAGES)-1:0]   mem_stage,
    output logic [2:0]                      mux_point,
    output logic                            mux_point_2_mode,
    output logic                            pe_valid,
    output logic                            busy,
    output logic                            done,
    output logic                            cfg_err
);

    localparam int STG_W  = $clog2(MAX_STAGES);
    localparam int GAP_W  = $clog2(STAGE_GAP + 1);
    localparam int PIPE_W = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             num_q, num_d;
    logic [2:0]             point_q  [MAX_STAGES];
    logic [2:0]             point_d  [MAX_STAGES];
    logic                   p2mode_q [MAX_STAGES];
    logic                   p2mode_d [MAX_STAGES];
    logic [GRP_WIDTH-1:0]   groups_q [MAX_STAGES];
    logic [GRP_WIDTH-1:0]   groups_d [MAX_STAGES];
    logic [STG_W-1:0]       stage_q, stage_d;
    logic [GRP_WIDTH-1:0]   grp_q, grp_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic                   cfg_err_q, cfg_err_d;
    logic [PIPE_W-1:0]      pipe_q [MEM_LAT];
    logic [PIPE_W-1:0]      pipe_d [MEM_LAT];

    logic [2:0]             in_point  [MAX_STAGES];
    logic                   in_p2     [MAX_STAGES];
    logic [GRP_WIDTH-1:0]   in_groups [MAX_STAGES];
    logic [MAX_STAGES-1:0]  stage_bad;
    logic                   cfg_ok;
    logic                   grp_last;
    logic                   gap_last;
    logic                   stage_last;
    logic                   issue;
    logic [2:0]             cur_point;
    logic                   cur_p2;

    // Unpack the flat config buses and flag any used stage with an illegal radix or zero groups.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_STAGES; gi++) begin : g_cfg
            localparam logic [2:0] STAGE_IDX = 3'(gi);
            logic point_legal;

            assign in_point[gi]  = cfg_stage_point[3*gi +: 3];
            assign in_p2[gi]     = cfg_stage_p2mode[gi];
            assign in_groups[gi] = cfg_stage_groups[GRP_WIDTH*gi +: GRP_WIDTH];

            always_comb begin
                case (in_point[gi])
                    3'd2, 3'd3, 3'd4, 3'd5, 3'd7: point_legal = 1'b1;
                    default:                      point_legal = 1'b0;
                endcase
            end

            assign stage_bad[gi] = (cfg_num_stages > STAGE_IDX) &&
                                   (!point_legal || (in_groups[gi] == '0));
        end
    endgenerate

    assign cfg_ok = (cfg_num_stages != 3'd0) &&
                    (cfg_num_stages <= 3'(MAX_STAGES)) &&
                    (stage_bad == '0);

    assign cur_point  = point_q[stage_q];
    assign cur_p2     = p2mode_q[stage_q] && (cur_point == 3'd2);
    assign grp_last   = (grp_q == (groups_q[stage_q] - GRP_WIDTH'(1)));
    assign gap_last   = (gap_q == GAP_W'(1));
    assign stage_last = ((3'(stage_q) + 3'd1) == num_q);
    assign issue      = (state_q == S_RUN) && pe_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        stage_d   = stage_q;
        grp_d     = grp_q;
        gap_d     = gap_q;
        cfg_err_d = 1'b0;
        for (int s = 0; s < MAX_STAGES; s++) begin
            point_d[s]  = point_q[s];
            p2mode_d[s] = p2mode_q[s];
            groups_d[s] = groups_q[s];
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        num_d   = cfg_num_stages;
                        stage_d = '0;
                        grp_d   = '0;
                        state_d = S_RUN;
                        for (int s = 0; s < MAX_STAGES; s++) begin
                            point_d[s]  = in_point[s];
                            p2mode_d[s] = in_p2[s];
                            groups_d[s] = in_groups[s];
                        end
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (pe_ready) begin
                    grp_d = grp_q + GRP_WIDTH'(1);
                    if (grp_last) begin
                        state_d = S_GAP;
                        gap_d   = GAP_W'(STAGE_GAP);
                    end
                end
            end
            S_GAP: begin
                if (gap_last) begin
                    grp_d = '0;
                    if (stage_last) begin
                        stage_d = '0;
                        state_d = S_IDLE;
                    end else begin
                        stage_d = stage_q + STG_W'(1);
                        state_d = S_RUN;
                    end
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Idle slots push zeros so the mux select falls back to 0 between issues.
        pipe_d[0] = issue ? {1'b1, cur_point, cur_p2} : '0;
        for (int i = 1; i < MEM_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_q     <= '0;
            stage_q   <= '0;
            grp_q     <= '0;
            gap_q     <= '0;
            cfg_err_q <= 1'b0;
            for (int s = 0; s < MAX_STAGES; s++) begin
                point_q[s]  <= '0;
                p2mode_q[s] <= 1'b0;
                groups_q[s] <= '0;
            end
            for (int i = 0; i < MEM_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            num_q     <= num_d;
            stage_q   <= stage_d;
            grp_q     <= grp_d;
            gap_q     <= gap_d;
            cfg_err_q <= cfg_err_d;
            for (int s = 0; s < MAX_STAGES; s++) begin
                point_q[s]  <= point_d[s];
                p2mode_q[s] <= p2mode_d[s];
                groups_q[s] <= groups_d[s];
            end
            for (int i = 0; i < MEM_LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    always_comb begin
        mem_rd_en        = issue;
        mem_rd_addr      = issue ? ADDR_WIDTH'(grp_q) : '0;
        mem_stage        = stage_q;
        pe_valid         = pipe_q[MEM_LAT-1][4];
        mux_point        = pipe_q[MEM_LAT-1][3:1];
        mux_point_2_mode = pipe_q[MEM_LAT-1][0];
        busy             = (state_q != S_IDLE);
        done             = (state_q == S_GAP) && gap_last && stage_last;
        cfg_err          = cfg_err_q;
    end

endmodule

// File: tb/tb_fft_stage_sched.sv
// Directed bench for fft_stage_sched: a schedule-level model predicts every output per cycle,
// and a few literal cycle/value pins anchor the model to hand-derived timing.
module tb_fft_stage_sched;

    localparam int AW = 10;
    localparam int GW = 10;
    localparam int MS = 4;
    localparam int ML = 1;
    localparam int SG = 4;
    localparam int SW = $clog2(MS);
    localparam int N  = 24;

    typedef struct packed {
        logic [2:0]             num;
        logic [MS-1:0][2:0]     point;
        logic [MS-1:0]          p2;
        logic [MS-1:0][GW-1:0]  groups;
    } cfg_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [2:0]         cfg_num_stages;
    logic [3*MS-1:0]    cfg_stage_point;
    logic [MS-1:0]      cfg_stage_p2mode;
    logic [GW*MS-1:0]   cfg_stage_groups;
    logic               pe_ready;
    logic               mem_rd_en;
    logic [AW-1:0]      mem_rd_addr;
    logic [SW-1:0]      mem_stage;
    logic [2:0]         mux_point;
    logic               mux_point_2_mode;
    logic               pe_valid;
    logic               busy;
    logic               done;
    logic               cfg_err;

    always #5 clk = ~clk;

    fft_stage_sched #(
        .ADDR_WIDTH (AW),
        .GRP_WIDTH  (GW),
        .MAX_STAGES (MS),
        .MEM_LAT    (ML),
        .STAGE_GAP  (SG)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .cfg_num_stages   (cfg_num_stages),
        .cfg_stage_point  (cfg_stage_point),
        .cfg_stage_p2mode (cfg_stage_p2mode),
        .cfg_stage_groups (cfg_stage_groups),
        .pe_ready         (pe_ready),
        .mem_rd_en        (mem_rd_en),
        .mem_rd_addr      (mem_rd_addr),
        .mem_stage        (mem_stage),
        .mux_point        (mux_point),
        .mux_point_2_mode (mux_point_2_mode),
        .pe_valid         (pe_valid),
        .busy             (busy),
        .done             (done),
        .cfg_err          (cfg_err)
    );

    int checks   = 0;
    int failures = 0;

    bit   sc_start [N];
    bit   sc_ready [N];
    bit   sc_rst   [N];
    cfg_t cfg_a, cfg_b;
    int   cfg_switch;

    int exp_rd[N], exp_addr[N], exp_stage[N], exp_valid[N], exp_point[N], exp_p2[N];
    int exp_busy[N], exp_done[N], exp_err[N];
    int got_rd[N], got_addr[N], got_stage[N], got_valid[N], got_point[N], got_p2[N];
    int got_busy[N], got_done[N], got_err[N];

    function automatic cfg_t mk(input int num, input int p0, input int m0, input int g0,
                                input int p1, input int m1, input int g1);
        cfg_t c;
        c           = '0;
        c.num       = 3'(num);
        c.point[0]  = 3'(p0);
        c.p2[0]     = 1'(m0);
        c.groups[0] = GW'(g0);
        c.point[1]  = 3'(p1);
        c.p2[1]     = 1'(m1);
        c.groups[1] = GW'(g1);
        return c;
    endfunction

    function automatic cfg_t cfg_at(input int c);
        return (c < cfg_switch) ? cfg_a : cfg_b;
    endfunction

    function automatic bit cfg_legal(input cfg_t cf);
        if (cf.num == 0 || int'(cf.num) > MS) return 1'b0;
        for (int s = 0; s < int'(cf.num); s++) begin
            if (!(int'(cf.point[s]) inside {2, 3, 4, 5, 7})) return 1'b0;
            if (cf.groups[s] == '0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void clear_exp(input int c);
        exp_rd[c] = 0; exp_addr[c] = 0; exp_stage[c] = 0; exp_valid[c] = 0;
        exp_point[c] = 0; exp_p2[c] = 0; exp_busy[c] = 0; exp_done[c] = 0; exp_err[c] = 0;
    endfunction

    // Lay out one accepted job: groups issue on ready cycles, each stage then idles SG cycles.
    function automatic int schedule(input int t, input cfg_t cf);
        int c = t + 1;
        for (int s = 0; s < int'(cf.num); s++) begin
            int g = 0;
            while (g < int'(cf.groups[s])) begin
                if (c >= N) return N;
                exp_busy[c] = 1;
                if (sc_ready[c]) begin
                    exp_rd[c]    = 1;
                    exp_addr[c]  = g;
                    exp_stage[c] = s;
                    if (c + ML < N) begin
                        exp_valid[c+ML] = 1;
                        exp_point[c+ML] = int'(cf.point[s]);
                        exp_p2[c+ML]    = (cf.point[s] == 3'd2) ? int'(cf.p2[s]) : 0;
                    end
                    g++;
                end
                c++;
            end
            for (int k = 0; k < SG; k++) begin
                if (c < N) exp_busy[c] = 1;
                c++;
            end
        end
        if (c - 1 < N) exp_done[c-1] = 1;
        return c - 1;
    endfunction

    function automatic void build_model();
        int free_from = 0;
        for (int c = 0; c < N; c++) clear_exp(c);
        for (int c = 0; c < N; c++) begin
            if (sc_rst[c]) begin
                for (int k = c + 1; k < N; k++) clear_exp(k);
                free_from = c + 1;
            end else if (sc_start[c] && c >= free_from) begin
                if (cfg_legal(cfg_at(c))) begin
                    free_from = schedule(c, cfg_at(c)) + 1;
                end else begin
                    if (c + 1 < N) exp_err[c+1] = 1;
                    free_from = c + 1;
                end
            end
        end
    endfunction

    task automatic chk(input string nm, input int c, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, c, got, exp);
        end
    endtask

    task automatic clear_stim();
        for (int c = 0; c < N; c++) begin
            sc_start[c] = 1'b0;
            sc_ready[c] = 1'b1;
            sc_rst[c]   = 1'b0;
        end
        cfg_switch = N;
        cfg_b      = '0;
    endtask

    task automatic drive_cfg(input cfg_t cf);
        cfg_num_stages   = cf.num;
        cfg_stage_point  = cf.point;
        cfg_stage_p2mode = cf.p2;
        cfg_stage_groups = cf.groups;
    endtask

    task automatic run_scenario(input string name);
        build_model();
        $display("scenario %s", name);
        rst      = 1'b1;
        start    = 1'b0;
        pe_ready = 1'b0;
        drive_cfg(cfg_at(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_outputs", -1,
            int'({mem_rd_en, mem_rd_addr, mem_stage, mux_point, mux_point_2_mode,
                  pe_valid, busy, done, cfg_err}), 0);
        @(posedge clk); #1;
        for (int c = 0; c < N; c++) begin
            rst      = sc_rst[c];
            start    = sc_start[c];
            pe_ready = sc_ready[c];
            drive_cfg(cfg_at(c));
            @(negedge clk);
            got_rd[c]    = int'(mem_rd_en);
            got_addr[c]  = int'(mem_rd_addr);
            got_stage[c] = int'(mem_stage);
            got_valid[c] = int'(pe_valid);
            got_point[c] = int'(mux_point);
            got_p2[c]    = int'(mux_point_2_mode);
            got_busy[c]  = int'(busy);
            got_done[c]  = int'(done);
            got_err[c]   = int'(cfg_err);
            if (got_rd[c] != 0)
                $display("  cycle %0d read stage %0d addr %0d", c, got_stage[c], got_addr[c]);
            chk("mem_rd_en", c, got_rd[c], exp_rd[c]);
            if (exp_rd[c] != 0) begin
                chk("mem_rd_addr", c, got_addr[c], exp_addr[c]);
                chk("mem_stage", c, got_stage[c], exp_stage[c]);
            end
            chk("pe_valid", c, got_valid[c], exp_valid[c]);
            chk("mux_point", c, got_point[c], exp_point[c]);
            chk("mux_point_2_mode", c, got_p2[c], exp_p2[c]);
            chk("busy", c, got_busy[c], exp_busy[c]);
            chk("done", c, got_done[c], exp_done[c]);
            chk("cfg_err", c, got_err[c], exp_err[c]);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pe_ready = 1'b0; drive_cfg('0);

        clear_stim();
        cfg_a = mk(1, 7, 0, 3, 0, 0, 0);
        sc_start[0] = 1'b1;
        run_scenario("single_p7_g3");
        chk("lit_s1_addr3", 3, got_addr[3], 2);
        chk("lit_s1_point4", 4, got_point[4], 7);
        chk("lit_s1_done7", 7, got_done[7], 1);
        chk("lit_s1_busy8", 8, got_busy[8], 0);

        clear_stim();
        cfg_a = mk(2, 4, 0, 2, 3, 0, 2);
        sc_start[0] = 1'b1;
        run_scenario("two_stage_p4_p3");
        chk("lit_s2_stage7", 7, got_stage[7], 1);
        chk("lit_s2_point9", 9, got_point[9], 3);
        chk("lit_s2_done12", 12, got_done[12], 1);

        clear_stim();
        cfg_a = mk(2, 2, 1, 2, 5, 1, 2);
        sc_start[0] = 1'b1;
        run_scenario("p2mode_then_p5");
        chk("lit_s3_p2_2", 2, got_p2[2], 1);
        chk("lit_s3_point9", 9, got_point[9], 5);
        chk("lit_s3_p2_9", 9, got_p2[9], 0);

        clear_stim();
        cfg_a = mk(1, 3, 0, 4, 0, 0, 0);
        sc_start[0] = 1'b1;
        sc_ready[2] = 1'b0;
        sc_ready[3] = 1'b0;
        run_scenario("pe_ready_stall");
        chk("lit_s4_rd2", 2, got_rd[2], 0);
        chk("lit_s4_addr4", 4, got_addr[4], 1);
        chk("lit_s4_valid7", 7, got_valid[7], 1);
        chk("lit_s4_done10", 10, got_done[10], 1);

        clear_stim();
        cfg_a = mk(1, 6, 0, 3, 0, 0, 0);
        sc_start[0] = 1'b1;
        run_scenario("reject_point6");
        chk("lit_s5a_err1", 1, got_err[1], 1);
        chk("lit_s5a_err2", 2, got_err[2], 0);
        chk("lit_s5a_busy1", 1, got_busy[1], 0);

        clear_stim();
        cfg_a = mk(2, 4, 0, 2, 3, 0, 0);
        sc_start[0] = 1'b1;
        run_scenario("reject_groups0");
        chk("lit_s5b_err1", 1, got_err[1], 1);
        chk("lit_s5b_rd1", 1, got_rd[1], 0);

        clear_stim();
        cfg_a = mk(0, 4, 0, 2, 0, 0, 0);
        sc_start[0] = 1'b1;
        run_scenario("reject_num0");
        chk("lit_s5c_err1", 1, got_err[1], 1);
        chk("lit_s5c_busy1", 1, got_busy[1], 0);

        clear_stim();
        cfg_a = mk(1, 7, 0, 3, 0, 0, 0);
        cfg_b = mk(2, 4, 0, 5, 3, 0, 1);
        cfg_switch = 1;
        sc_start[0] = 1'b1;
        sc_start[3] = 1'b1;
        sc_start[7] = 1'b1;
        sc_start[8] = 1'b1;
        run_scenario("start_during_job");
        chk("lit_s6_addr3", 3, got_addr[3], 2);
        chk("lit_s6_done7", 7, got_done[7], 1);
        chk("lit_s6_rd8", 8, got_rd[8], 0);
        chk("lit_s6_rd9", 9, got_rd[9], 1);
        chk("lit_s6_point10", 10, got_point[10], 4);
        chk("lit_s6_done22", 22, got_done[22], 1);

        clear_stim();
        cfg_a = mk(1, 5, 0, 8, 0, 0, 0);
        sc_start[0] = 1'b1;
        sc_rst[2]   = 1'b1;
        sc_start[3] = 1'b1;
        run_scenario("reset_in_run");
        chk("lit_s7_rd2", 2, got_rd[2], 1);
        chk("lit_s7_valid3", 3, got_valid[3], 0);
        chk("lit_s7_busy3", 3, got_busy[3], 0);
        chk("lit_s7_rd4", 4, got_rd[4], 1);
        chk("lit_s7_addr4", 4, got_addr[4], 0);
        chk("lit_s7_done15", 15, got_done[15], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_stage_sched.md
# fft_stage_sched

Sequencer for the configurable mixed-radix FFT datapath. It latches a multi-stage job (per-stage radix, point-2 mode, group count) and issues memory-bank read addresses one group per cycle. It drives the input reindex mux's `point`/`point_2_mode` select and the PE valid strobe, delayed to line up with bank read data. It sits between the top-level FFT control and the memory banks / input mux / PE array.

## Interface
Parameters:
- `ADDR_WIDTH`, 10: bank read address width.
- `GRP_WIDTH`, 10: per-stage group count width.
- `MAX_STAGES`, 4: maximum stages per job (≤7).
- `MEM_LAT`, 1: bank read latency in cycles (≥1).
- `STAGE_GAP`, 4: idle cycles after each stage's last read for PE write-back (≥ `MEM_LAT`).

Ports:
- `clk` in 1: clock. One clock domain, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: job request, sampled only in IDLE.
- `cfg_num_stages` in 3: number of stages, 1..`MAX_STAGES`.
- `cfg_stage_point` in 3*`MAX_STAGES`: radix of stage s in bits [3s+2:3s]; legal values 2,3,4,5,7.
- `cfg_stage_p2mode` in `MAX_STAGES`: point_2_mode for stage s; meaningful only when point=2.
- `cfg_stage_groups` in `GRP_WIDTH`*`MAX_STAGES`: group count for stage s; must be ≥1.
- `pe_ready` in 1: PE permits a new issue this cycle.
- `mem_rd_en` out 1: bank read strobe.
- `mem_rd_addr` out `ADDR_WIDTH`: group index within the current stage, zero-extended.
- `mem_stage` out `$clog2(MAX_STAGES)`: current stage index.
- `mux_point` out 3: input mux radix select, aligned with bank data.
- `mux_point_2_mode` out 1: input mux mode select, aligned with bank data.
- `pe_valid` out 1: bank data at the mux is valid.
- `busy` out 1: job in progress.
- `done` out 1: one-cycle job-complete pulse.
- `cfg_err` out 1: one-cycle pulse when a start is rejected.

## Operation
- States: IDLE, RUN, GAP.
- **IDLE, `start`=1:**
  - Validate the config. It is invalid if `cfg_num_stages` is 0 or >`MAX_STAGES`, or any used stage has point ∉{2,3,4,5,7} or groups=0.
  - Invalid: pulse `cfg_err` next cycle and stay in IDLE.
  - Valid: latch the whole config, set stage=0 and grp=0, go to RUN. `busy` asserts next cycle.
- **RUN:**
  - Each cycle with `pe_ready`=1: assert `mem_rd_en` with `mem_rd_addr`=grp, `mem_stage`=stage, then increment grp.
  - When grp = groups−1 is issued: go to GAP and load the gap counter with `STAGE_GAP`.
  - With `pe_ready`=0: no issue, grp holds.
- **GAP:**
  - Lasts exactly `STAGE_GAP` cycles. No reads are issued and `pe_ready` is ignored.
  - In the last GAP cycle, if stage < num_stages−1: stage++, grp=0, next state RUN.
  - Otherwise: `done`=1 that cycle and next state is IDLE.
- **Alignment pipe:** a `MEM_LAT`-deep register chain carries {rd_en, point, p2mode} of each issue to {`pe_valid`, `mux_point`, `mux_point_2_mode`}.
  - Non-valid slots carry point=0 and p2mode=0, so the mux outputs zeros.
  - p2mode is forced to 0 when point≠2.
- **PE flow control:** `pe_ready` is a stop-issue signal only. Reads already in flight (≤`MEM_LAT`) always produce `pe_valid`; the PE absorbs them.
- `start` while `busy` is ignored. The latched config is immune to `cfg_*` changes during a job.
- **Group counter width:** grp is `GRP_WIDTH` bits and never wraps. The terminal compare is against groups−1.

## Timing
- **Reset values:** every output is 0, state is IDLE, and the alignment pipe and all counters are cleared.
- **Reset mid-job:** the job is abandoned next cycle, with no `done` and no further `pe_valid`.
- **Start acceptance:** `start` accepted in cycle t gives RUN in t+1, and the first `mem_rd_en` at t+1 if `pe_ready`=1.
- **Alignment latency:** `pe_valid`, `mux_point` and `mux_point_2_mode` follow the corresponding `mem_rd_en` by exactly `MEM_LAT` cycles.
- **Busy window:** `busy`=1 from t+1 through the `done` cycle inclusive. `done` and the final `busy` cycle coincide.
- **Minimum job length:** with `pe_ready`=1 throughout, job length = Σgroups + num_stages·`STAGE_GAP` cycles.
- **Back-to-back jobs:** a new `start` is accepted in the cycle after `done` at the earliest.
- **`cfg_err` timing:** `cfg_err` asserts in cycle t+1 only, with `busy`=0.

## Test plan
All scenarios use `MEM_LAT`=1 and `STAGE_GAP`=4, with start in cycle 0.
- **Single stage, point=7, groups=3, `pe_ready`=1:**
  - `mem_rd_en` in cycles 1–3 with addr 0,1,2.
  - `pe_valid`/`mux_point`=7 in cycles 2–4.
  - `done` in cycle 7; `busy` in cycles 1–7.
- **Two stages, {4, groups 2} then {3, groups 2}:**
  - Stage 0 reads in cycles 1–2; stage 1 reads in cycles 7–8 with `mem_stage`=1 and addr 0,1.
  - `mux_point`=4 in cycles 2–3 and 3 in cycles 8–9.
  - `done` in cycle 12.
- **Point=2, p2mode=1, groups=2, then point=5, p2mode=1:**
  - `mux_point_2_mode`=1 only on the point-2 valid cycles; it is 0 on the point-5 cycles.
- **Single stage, point=3, groups=4, `pe_ready` low in cycles 2–3:**
  - Reads in cycles 1,4,5,6 with addr 0,1,2,3.
  - `pe_valid` in cycles 2,5,6,7.
  - `done` in cycle 10.
- **Rejected configs:**
  - point=6, or groups=0, or `cfg_num_stages`=0 → `cfg_err`=1 in cycle 1 only; no `busy` and no reads.
  - `start` pulsed during a job → ignored, with no change to the job.
- **Reset in RUN:** `rst` asserted in cycle 2 of a groups=8 job → cycle 3 has all outputs 0 and state IDLE. No `done` follows, and a new start in cycle 3 is accepted normally.
